// File: rtl/program_sequencer.sv
// -----------------------------------------------------------------------------
// program_sequencer
//
// Drives the instruction-memory address (pc) every cycle. It supports
// sequential increment, absolute jumps, signed relative branches, jumps
// through a writable far-target table, and call/return through a small
// LIFO return-address stack. Stack misuse is recorded in sticky error flags.
//
// Ports:
//   clock      rising-edge clock
//   start      asynchronous active-high reset (clears every state element)
//   stall      hold pc, stack, depth and flags; far-table writes still land
//   jump_en    take the transfer selected by jump_mode
//   jump_mode  00 absolute, 01 relative, 10 far-table, 11 return
//   call       with a taken jump of mode 00/01/10, push pc+1
//   target     jump operand from the instruction
//   far_we     far-table write enable
//   far_addr   far-table write index
//   far_data   far-table write data
//   pc         current program counter (registered)
//   depth      live stack occupancy (registered)
//   ovf_err    sticky stack overflow (registered)
//   unf_err    sticky stack underflow (registered)
// -----------------------------------------------------------------------------
module program_sequencer #(
  parameter int PC_BITS     = 12,
  parameter int TARGET_BITS = 8,
  parameter int FAR_ENTRIES = 4,
  parameter int STACK_DEPTH = 4,
  localparam int FI = $clog2(FAR_ENTRIES),
  localparam int SC = $clog2(STACK_DEPTH) + 1
) (
  input  logic                   clock,
  input  logic                   start,
  input  logic                   stall,
  input  logic                   jump_en,
  input  logic [1:0]             jump_mode,
  input  logic                   call,
  input  logic [TARGET_BITS-1:0] target,
  input  logic                   far_we,
  input  logic [FI-1:0]          far_addr,
  input  logic [PC_BITS-1:0]     far_data,
  output logic [PC_BITS-1:0]     pc,
  output logic [SC-1:0]          depth,
  output logic                   ovf_err,
  output logic                   unf_err
);

  // Jump mode encodings.
  localparam logic [1:0] MODE_ABS = 2'b00;
  localparam logic [1:0] MODE_REL = 2'b01;
  localparam logic [1:0] MODE_FAR = 2'b10;
  localparam logic [1:0] MODE_RET = 2'b11;

  // Architectural state.
  logic [PC_BITS-1:0] pc_reg;
  logic [PC_BITS-1:0] pc_next;
  logic [SC-1:0]      depth_reg;
  logic [SC-1:0]      depth_next;
  logic               ovf_reg;
  logic               ovf_next;
  logic               unf_reg;
  logic               unf_next;

  // Storage. Both arrays must clear on reset, so they live in flops.
  logic [PC_BITS-1:0] far_mem   [FAR_ENTRIES];
  logic [PC_BITS-1:0] stack_mem [STACK_DEPTH];

  // Per-entry write strobes.
  logic [FAR_ENTRIES-1:0] far_sel;
  logic [STACK_DEPTH-1:0] push_sel;

  // Candidate next-pc values and stack status.
  logic               push_en;
  logic [PC_BITS-1:0] pc_inc;
  logic [PC_BITS-1:0] rel_target;
  logic [PC_BITS-1:0] far_target;
  logic [PC_BITS-1:0] top_value;
  logic               stack_full;
  logic               stack_empty;

  // pc+1 doubles as the sequential successor and the return address to push.
  assign pc_inc = pc_reg + PC_BITS'(1);

  // Relative branch: sign-extend the operand; the sum wraps naturally.
  assign rel_target = pc_reg + {{(PC_BITS-TARGET_BITS){target[TARGET_BITS-1]}}, target};

  // Only the low FI bits of the operand index the far table. The read uses
  // the pre-edge contents, so a same-cycle write to that index is not seen.
  assign far_target = far_mem[target[FI-1:0]];

  assign stack_full  = (depth_reg == SC'(STACK_DEPTH));
  assign stack_empty = (depth_reg == '0);

  // Top of stack is entry depth-1; zero when empty (never used in that case).
  always_comb begin
    top_value = '0;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (depth_reg == SC'(i + 1)) begin
        top_value = stack_mem[i];
      end
    end
  end

  // Write decode for the far table and the stack slot at the current depth.
  generate
    for (genvar gi = 0; gi < FAR_ENTRIES; gi++) begin : g_far_sel
      assign far_sel[gi] = far_we && (far_addr == FI'(gi));
    end
    for (genvar gi = 0; gi < STACK_DEPTH; gi++) begin : g_push_sel
      assign push_sel[gi] = push_en && (depth_reg == SC'(gi));
    end
  endgenerate

  // Next-state decision. Priority: stall, then jump_en, then increment.
  always_comb begin
    pc_next    = pc_reg;
    depth_next = depth_reg;
    ovf_next   = ovf_reg;
    unf_next   = unf_reg;
    push_en    = 1'b0;

    if (!stall) begin
      if (jump_en) begin
        unique case (jump_mode)
          MODE_ABS: pc_next = PC_BITS'(target);
          MODE_REL: pc_next = rel_target;
          MODE_FAR: pc_next = far_target;
          MODE_RET: begin
            if (!stack_empty) begin
              pc_next    = top_value;
              depth_next = depth_reg - SC'(1);
            end else begin
              // Return with nothing to pop: fall through and flag it.
              pc_next  = pc_inc;
              unf_next = 1'b1;
            end
          end
          default: pc_next = pc_reg;
        endcase

        // A call rides on any taken non-return jump. When full, the push is
        // dropped but the jump itself still happens.
        if (call && (jump_mode != MODE_RET)) begin
          if (stack_full) begin
            ovf_next = 1'b1;
          end else begin
            push_en    = 1'b1;
            depth_next = depth_reg + SC'(1);
          end
        end
      end else begin
        pc_next = pc_inc;
      end
    end
  end

  // Control state.
  always_ff @(posedge clock or posedge start) begin
    if (start) begin
      pc_reg    <= '0;
      depth_reg <= '0;
      ovf_reg   <= 1'b0;
      unf_reg   <= 1'b0;
    end else begin
      pc_reg    <= pc_next;
      depth_reg <= depth_next;
      ovf_reg   <= ovf_next;
      unf_reg   <= unf_next;
    end
  end

  // Far-target table; writes are independent of stall.
  always_ff @(posedge clock or posedge start) begin
    if (start) begin
      for (int i = 0; i < FAR_ENTRIES; i++) begin
        far_mem[i] <= '0;
      end
    end else begin
      for (int i = 0; i < FAR_ENTRIES; i++) begin
        if (far_sel[i]) begin
          far_mem[i] <= far_data;
        end
      end
    end
  end

  // Return-address stack; a push writes the slot just above the top.
  always_ff @(posedge clock or posedge start) begin
    if (start) begin
      for (int i = 0; i < STACK_DEPTH; i++) begin
        stack_mem[i] <= '0;
      end
    end else begin
      for (int i = 0; i < STACK_DEPTH; i++) begin
        if (push_sel[i]) begin
          stack_mem[i] <= pc_inc;
        end
      end
    end
  end

  assign pc      = pc_reg;
  assign depth   = depth_reg;
  assign ovf_err = ovf_reg;
  assign unf_err = unf_reg;

endmodule

// File: doc/program_sequencer.md
Name: program_sequencer

Overview:
- Parametrised successor to the single-mode program counter; drives instruction-memory address `pc` each cycle.
- Adds signed relative branches and a writable far-target table replacing hard-coded far jump addresses.
- Adds a call/return stack, stall hold and sticky stack-error flags.
- Sits between the decoder (jump/call/return controls, target field) and instruction ROM.

Parameters:
- PC_BITS, 12, width of pc and stack entries.
- TARGET_BITS, 8, width of target field from instruction; must be < PC_BITS.
- FAR_ENTRIES, 4, far-target table entries (power of 2, >=2); index width FI = log2(FAR_ENTRIES).
- STACK_DEPTH, 4, return-address stack entries (>=1); count width SC = log2(STACK_DEPTH)+1.

Ports:
- clock, input, 1, rising-edge clock.
- start, input, 1, asynchronous active-high reset.
- stall, input, 1, hold pc and stack this cycle.
- jump_en, input, 1, take control transfer selected by jump_mode.
- jump_mode, input, 2, 00 absolute, 01 relative, 10 far-table, 11 return.
- call, input, 1, with a taken jump of mode 00/01/10, push pc+1.
- target, input, TARGET_BITS, jump operand.
- far_we, input, 1, far-table write enable.
- far_addr, input, FI, far-table write index.
- far_data, input, PC_BITS, far-table write data.
- pc, output, PC_BITS, current program counter.
- depth, output, SC, live stack occupancy.
- ovf_err, output, 1, sticky stack overflow.
- unf_err, output, 1, sticky stack underflow.

Behaviour:
- Reset (start high, asynchronous, any time, including mid-jump or mid-stall) forces:
  - pc=0, depth=0, ovf_err=0, unf_err=0.
  - All far-table entries and all stack entries = 0.
- While start is high, every state element holds its reset value; the first update is the first rising edge after start falls.
- Priority at each edge, start low: stall > jump_en > sequential increment.
- stall=1:
  - pc, stack, depth and error flags hold.
  - Far-table write still performed.
  - call and jump_en ignored.
- jump_en=1, stall=0, next pc by jump_mode:
  - 00: {zero-ext target}.
  - 01: pc + sign-ext(target), modulo 2^PC_BITS.
  - 10: far_table[target[FI-1:0]]; upper target bits ignored.
  - 11 (return):
    - depth>0: pop top entry to pc, depth-1.
    - depth=0: pc <= pc+1, depth stays 0, unf_err <= 1.
- call with jump_mode 00/01/10 and jump taken: push (pc+1 mod 2^PC_BITS).
  - depth<STACK_DEPTH: depth+1.
  - depth=STACK_DEPTH: push dropped, stack unchanged, ovf_err <= 1, jump still taken.
- call with jump_mode 11: call ignored; return semantics only.
- call with jump_en=0: ignored.
- No jump, no stall: pc <= pc+1, wrapping from 2^PC_BITS-1 to 0.
- Stack is LIFO, tracked by depth only; no circular overwrite.
- Latency: pc reflects the decision one cycle after the controlling inputs are sampled; no combinational path from inputs to pc.
- Far-table write:
  - Takes effect at the edge: mem[far_addr] <= far_data.
  - A far jump in the same cycle reading the same index uses the old value.
  - A write has no effect on pc.
- ovf_err/unf_err are sticky; cleared only by start.
- All outputs registered.

Test Plan:
- Reset then 5 free-run cycles -> pc 0,1,2,3,4,5; depth=0; flags 0; assert start asynchronously mid-cycle -> pc=0 immediately, before next edge.
- PC_BITS=12, pc=100, jump_mode=01, target=8'hF6 (-10) -> pc=90; then target=8'h05 -> pc=95; pc=4090 with target=8'h0A -> pc=4 (wrap).
- far_we addr=1 data=470, then jump_mode=10 target=8'hFD -> pc=470. In the same cycle, write addr=1 data=435 with a far jump to index 1 -> pc=470; a later far jump to index 1 -> pc=435.
- Nested calls: pc=10 call abs 200; at 200 call abs 300; at 300 return -> pc=201; return -> pc=11; depth 0; another return -> pc=12, unf_err=1.
- STACK_DEPTH=4: five consecutive call jumps -> depth=4, ovf_err=1, 5th target still reached; four returns pop the first four return addresses in reverse order.
- stall=1 with jump_en=1, call=1 for 3 cycles at pc=50 -> pc stays 50, depth unchanged; release stall with jump abs 7 -> pc=7.
